// File: rtl/yuyin_pkg.sv
// Shared types and constants for the voice-clip playback scheduler.
package yuyin_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DROP_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_PLAYING   = 3'd3,
        ST_GAP       = 3'd4
    } sched_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/yuyin_req_fifo.sv
// Request queue: synchronous FIFO with first-word-fall-through head output.
module yuyin_req_fifo
    import yuyin_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Pointer comparison with an extra wrap bit distinguishes full from empty.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                  (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem[rd_ptr[IDX_W-1:0]];
    end

    // Pointer update; reset only empties the queue, storage is left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; when full, the slot written is the one being popped this cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/yuyin_play_sched.sv
// Voice-clip playback scheduler: arbitrates key/UART requests into a queue and
// plays them one at a time on the voice chip.
// Optional watchdog on the chip-busy waits: define YUYIN_TIMEOUT_EN.
module yuyin_play_sched
    import yuyin_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned START_CYC   = 50,
    parameter int unsigned GAP_CYC     = 1000,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_req,
    input  logic [ADDR_W-1:0]     uart_addr,
    input  logic                  key_req,
    input  logic [ADDR_W-1:0]     key_addr,
    input  logic                  play_busy,
    output logic [ADDR_W-1:0]     play_addr,
    output logic                  play_start,
    output logic                  sched_busy,
    output logic                  fifo_full,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned CNT_W = $clog2(max3(START_CYC, GAP_CYC, TIMEOUT_CYC) + 1);

    sched_state_t          state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  any_req, push, pop, load_addr, abort;
    logic                  fifo_empty, fifo_full_i;
    logic [ADDR_W-1:0]     push_addr, head_addr;
    logic [1:0]            drop_inc;
    logic [DROP_CNT_W+1:0] drop_sum;

    yuyin_req_fifo #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_addr),
        .pop       (pop),
        .head      (head_addr),
        .full      (fifo_full_i),
        .empty     (fifo_empty)
    );

    // Enqueue mux: key wins a same-cycle collision; a full queue still accepts when popping.
    always_comb begin
        any_req   = key_req | uart_req;
        push_addr = key_req ? key_addr : uart_addr;
        push      = any_req & (~fifo_full_i | pop);
        drop_inc  = {1'b0, key_req & uart_req} + {1'b0, any_req & ~push} + {1'b0, abort};
        drop_sum  = {2'b00, drop_cnt} + {{DROP_CNT_W{1'b0}}, drop_inc};
    end

`ifdef YUYIN_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt, wd_cnt_n;
    logic             wd_expired;

    // Watchdog counts cycles spent in a busy-wait state; cleared on any state change.
    always_ff @(posedge clk) begin
        if (rst) wd_cnt <= '0;
        else     wd_cnt <= wd_cnt_n;
    end

    // Watchdog next value and expiry flag.
    always_comb begin
        wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
        wd_cnt_n   = '0;
        if ((state == ST_WAIT_BUSY || state == ST_PLAYING) && state_n == state)
            wd_cnt_n = wd_cnt + 1'b1;
    end
`endif

    // State, cycle counter, latched address and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            play_addr <= '0;
            drop_cnt  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load_addr) play_addr <= head_addr;
            if (drop_sum[DROP_CNT_W+1:DROP_CNT_W] != 2'b00) drop_cnt <= '1;
            else                                           drop_cnt <= drop_sum[DROP_CNT_W-1:0];
        end
    end

    // Playback sequencing: next state, pop request and counter control.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pop       = 1'b0;
        load_addr = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load_addr = 1'b1;
                    cnt_n     = '0;
                    state_n   = ST_START;
                end
            end
            ST_START: begin
                if (cnt == CNT_W'(START_CYC - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_WAIT_BUSY;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_WAIT_BUSY: begin
                if (play_busy) state_n = ST_PLAYING;
`ifdef YUYIN_TIMEOUT_EN
                else if (wd_expired) begin
                    cnt_n   = '0;
                    abort   = 1'b1;
                    state_n = ST_GAP;
                end
`endif
            end
            ST_PLAYING: begin
                if (!play_busy) begin
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end
`ifdef YUYIN_TIMEOUT_EN
                else if (wd_expired) begin
                    cnt_n   = '0;
                    abort   = 1'b1;
                    state_n = ST_GAP;
                end
`endif
            end
            ST_GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Chip-facing and status outputs.
    always_comb begin
        play_start = (state == ST_START);
        sched_busy = (state != ST_IDLE) | ~fifo_empty;
        fifo_full  = fifo_full_i;
    end

endmodule
